// File: rtl/pixel_stream_sequencer_pkg.sv
// pixel_stream_sequencer_pkg: shared widths, frame defaults and sequencer states
package pixel_stream_sequencer_pkg;
    localparam int PIXEL_SIZE       = 24;
    localparam int WORD_SIZE        = 16;
    localparam int FRAME_WIDTH_DEF  = 550;
    localparam int FRAME_HEIGHT_DEF = 480;
    typedef enum logic [2:0] {IDLE, ACTIVE, HBLANK, FLUSH, VBLANK} state_e;
endpackage

// File: rtl/raster_counter.sv
// raster_counter: raster-order x/y position with row and frame wrap
module raster_counter import pixel_stream_sequencer_pkg::*; #(
    parameter int W = FRAME_WIDTH_DEF,
    parameter int H = FRAME_HEIGHT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 en_i,
    output logic [WORD_SIZE-1:0] x_o,
    output logic [WORD_SIZE-1:0] y_o
);
    localparam logic [WORD_SIZE-1:0] X_MAX = WORD_SIZE'(W - 1);
    localparam logic [WORD_SIZE-1:0] Y_MAX = WORD_SIZE'(H - 1);
    logic [WORD_SIZE-1:0] x_q, x_d, y_q, y_d;
    // step x on enable; end of row wraps x and advances y, end of frame wraps both
    always_comb begin
        x_d = clr_i ? '0 : !en_i ? x_q : (x_q == X_MAX) ? '0 : x_q + 1'b1;
        y_d = clr_i ? '0 : !(en_i && x_q == X_MAX) ? y_q : (y_q == Y_MAX) ? '0 : y_q + 1'b1;
    end
    // position registers
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end
    assign x_o = x_q;
    assign y_o = y_q;
endmodule

// File: rtl/pixel_stream_sequencer.sv
// pixel_stream_sequencer: feeds one frame through a fixed-latency datapath and tags aligned outputs
module pixel_stream_sequencer #(
    parameter int FRAME_WIDTH  = pixel_stream_sequencer_pkg::FRAME_WIDTH_DEF,
    parameter int FRAME_HEIGHT = pixel_stream_sequencer_pkg::FRAME_HEIGHT_DEF,
    parameter int PIXEL_SIZE   = pixel_stream_sequencer_pkg::PIXEL_SIZE,
    parameter int LATENCY      = 2 * FRAME_WIDTH + 3
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic                                       s_valid,
    output logic                                       s_ready,
    input  logic [PIXEL_SIZE-1:0]                      s_data,
    output logic                                       pipe_en,
    output logic                                       pipe_hsync,
    output logic                                       pipe_vsync,
    output logic [PIXEL_SIZE-1:0]                      pipe_data,
    output logic                                       m_valid,
    output logic [pixel_stream_sequencer_pkg::WORD_SIZE-1:0] m_x,
    output logic [pixel_stream_sequencer_pkg::WORD_SIZE-1:0] m_y,
    output logic [31:0]                                frame,
    output logic                                       busy,
    output logic                                       done
);
    import pixel_stream_sequencer_pkg::*;
    localparam logic [31:0]          LAT   = 32'(LATENCY);
    localparam logic [WORD_SIZE-1:0] X_END = WORD_SIZE'(FRAME_WIDTH - 1);
    localparam logic [WORD_SIZE-1:0] Y_END = WORD_SIZE'(FRAME_HEIGHT - 1);
    state_e               state_q, state_d;
    logic [31:0]          adv_q, adv_d, flush_q, flush_d, frame_q, frame_d;
    logic [WORD_SIZE-1:0] in_x, in_y;
    logic                 xfer, idle;
    assign idle    = state_q == IDLE;
    assign xfer    = state_q == ACTIVE && s_valid;
    assign m_valid = pipe_en && adv_q == LAT;
    assign busy    = !idle;
    assign frame   = frame_q;
    raster_counter #(.W(FRAME_WIDTH), .H(FRAME_HEIGHT)) u_in (
        .clk(clk), .rst(reset), .clr_i(idle), .en_i(xfer), .x_o(in_x), .y_o(in_y)
    );
    raster_counter #(.W(FRAME_WIDTH), .H(FRAME_HEIGHT)) u_out (
        .clk(clk), .rst(reset), .clr_i(idle), .en_i(m_valid), .x_o(m_x), .y_o(m_y)
    );
    // sequencing and datapath strobes; input pixels pass straight through on transfer
    always_comb begin
        state_d    = state_q;
        s_ready    = 1'b0;
        pipe_en    = 1'b0;
        pipe_data  = '0;
        pipe_hsync = 1'b0;
        pipe_vsync = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE:    state_d = start ? ACTIVE : IDLE;
            ACTIVE: begin
                s_ready   = 1'b1;
                pipe_en   = s_valid;
                pipe_data = s_valid ? s_data : '0;
                if (s_valid && in_x == X_END) state_d = (in_y == Y_END) ? FLUSH : HBLANK;
            end
            HBLANK: begin
                pipe_hsync = 1'b1;
                state_d    = ACTIVE;
            end
            FLUSH: begin
                pipe_en = 1'b1;
                state_d = (flush_q == LAT - 1) ? VBLANK : FLUSH;
            end
            VBLANK: begin
                pipe_vsync = 1'b1;
                done       = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // advance count saturates at the latency so it marks when outputs become real
    always_comb begin
        adv_d   = idle ? '0 : (pipe_en && adv_q != LAT) ? adv_q + 1 : adv_q;
        flush_d = state_q == FLUSH ? flush_q + 1 : '0;
        frame_d = state_q == VBLANK ? frame_q + 1 : frame_q;
    end
    // state and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            adv_q   <= '0;
            flush_q <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            adv_q   <= adv_d;
            flush_q <= flush_d;
            frame_q <= frame_d;
        end
    end
endmodule

// File: tb/tb_pixel_stream_sequencer.sv
// tb_pixel_stream_sequencer: scoreboard bench for a 4x3 frame with latency 11
module tb_pixel_stream_sequencer;
    localparam int FW = 4;
    localparam int FH = 3;
    localparam int LAT = 11;
    logic        clk = 1'b0;
    logic        reset, start, s_valid, s_ready;
    logic [23:0] s_data, pipe_data;
    logic        pipe_en, pipe_hsync, pipe_vsync, m_valid, busy, done;
    logic [15:0] m_x, m_y;
    logic [31:0] frame;
    int errors = 0, checks = 0;
    int n_xfer = 0, n_flush = 0, n_hs = 0, n_vs = 0, n_done = 0, n_mv = 0;
    int adv = 0, ix = 0, iy = 0;
    logic [31:0] sb_q[$];

    pixel_stream_sequencer #(.FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .PIXEL_SIZE(24), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .pipe_en(pipe_en), .pipe_hsync(pipe_hsync), .pipe_vsync(pipe_vsync),
        .pipe_data(pipe_data), .m_valid(m_valid), .m_x(m_x), .m_y(m_y), .frame(frame),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic monitor();
        logic [31:0] exp;
        if (!busy) begin
            adv = 0;
            ix = 0;
            iy = 0;
        end
        check("mvalid", m_valid, pipe_en && adv == LAT);
        if (pipe_en && adv != LAT) adv++;
        if (pipe_en && s_ready) begin
            n_xfer++;
            check("pdata", pipe_data, s_data);
            sb_q.push_back({16'(iy), 16'(ix)});
            if (ix == FW - 1) begin
                ix = 0;
                iy = (iy == FH - 1) ? 0 : iy + 1;
            end else ix++;
        end else if (pipe_en) begin
            n_flush++;
            check("fdata", pipe_data, 0);
        end else check("idata", pipe_data, 0);
        check("excl", (pipe_hsync && pipe_vsync) || ((pipe_hsync || pipe_vsync) && pipe_en), 0);
        if (m_valid) begin
            n_mv++;
            check("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                exp = sb_q.pop_front();
                check("mxy", {m_y, m_x}, exp);
            end
        end
        n_hs += int'(pipe_hsync);
        n_vs += int'(pipe_vsync);
        n_done += int'(done);
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        @(negedge clk);
        check(tag, {s_ready, pipe_en, pipe_hsync, pipe_vsync, m_valid, busy, done}, 0);
        check({tag, "_data"}, {pipe_data, m_x, m_y}, 0);
        check({tag, "_frame"}, frame, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input bit toggle, input bit start_mid, input int exp_frame);
        int cyc = 0;
        int x0 = n_xfer, f0 = n_flush, h0 = n_hs, v0 = n_vs, d0 = n_done, m0 = n_mv;
        s_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (n_done == d0 && cyc < 200) begin
            s_valid = toggle ? cyc[0] : 1'b1;
            s_data = 24'($urandom);
            start = start_mid && (cyc == 5 || cyc == 20);
            tick();
            cyc++;
        end
        start = 1'b0;
        s_valid = 1'b0;
        check("timeout", cyc < 200, 1);
        check("xfers", n_xfer - x0, FW * FH);
        check("flush", n_flush - f0, LAT);
        check("hsync", n_hs - h0, FH - 1);
        check("vsync", n_vs - v0, 1);
        check("dones", n_done - d0, 1);
        check("mvalids", n_mv - m0, FW * FH);
        check("sb_left", sb_q.size(), 0);
        check("frame", frame, exp_frame);
        @(negedge clk);
        check("idle_busy", busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k, d_before;
        reset = 1'b1;
        start = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_zero("reset");
        run_frame(1'b0, 1'b0, 1);
        run_frame(1'b1, 1'b0, 2);
        d_before = n_done;
        k = n_xfer;
        s_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 50 && n_xfer - k < 6; c++) begin
            s_data = 24'($urandom);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb_q.delete();
        chk_zero("midrst");
        check("midrst_done", n_done, d_before);
        run_frame(1'b0, 1'b1, 1);
        run_frame(1'b0, 1'b0, 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
